// File: rtl/dmem_arbiter.sv
// Round-robin two-requester front end for a single-port word memory.
// Sub-word stores become read-modify-write; sub-word loads are extracted and extended.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [1:0]        m0_size,
    input  logic              m0_uns,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [1:0]        m1_size,
    input  logic              m1_uns,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_done,
    output logic              m1_done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_A,
    output logic [DATA_W-1:0] mem_WD,
    output logic              mem_WE,
    input  logic [DATA_W-1:0] mem_RD
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRead  = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    logic [1:0]        state_q;
    logic              last_grant_q;
    logic              win_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] buf_q;
    logic              err_q;
    logic [1:0]        gnt_q;

    logic              pick;
    logic              sel_we;
    logic [1:0]        sel_size;
    logic              sel_uns;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_err;

    // With both requesting, the requester that did not win last time goes next.
    always_comb begin
        pick      = (m0_req && m1_req) ? ~last_grant_q : m1_req;
        sel_we    = pick ? m1_we    : m0_we;
        sel_size  = pick ? m1_size  : m0_size;
        sel_uns   = pick ? m1_uns   : m0_uns;
        sel_addr  = pick ? m1_addr  : m0_addr;
        sel_wdata = pick ? m1_wdata : m0_wdata;
        sel_err   = (sel_size == 2'b11) ||
                    (sel_size == 2'b01 && sel_addr[0]) ||
                    (sel_size == 2'b10 && sel_addr[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            win_q        <= 1'b0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            buf_q        <= '0;
            err_q        <= 1'b0;
            gnt_q        <= 2'b00;
        end else begin
            gnt_q <= 2'b00;
            unique case (state_q)
                StIdle: begin
                    if (m0_req || m1_req) begin
                        win_q        <= pick;
                        last_grant_q <= pick;
                        gnt_q        <= pick ? 2'b10 : 2'b01;
                        we_q         <= sel_we;
                        size_q       <= sel_size;
                        uns_q        <= sel_uns;
                        addr_q       <= sel_addr;
                        wdata_q      <= sel_wdata;
                        err_q        <= sel_err;
                        if (sel_err) begin
                            state_q <= StResp;
                        end else if (sel_we && sel_size == 2'b10) begin
                            state_q <= StWrite;
                        end else begin
                            state_q <= StRead;
                        end
                    end
                end
                StRead: begin
                    buf_q   <= mem_RD;
                    state_q <= we_q ? StWrite : StResp;
                end
                StWrite: state_q <= StResp;
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [DATA_W-1:0] ext_v;
    logic [DATA_W-1:0] merged;

    always_comb begin
        unique case (addr_q[1:0])
            2'd0: byte_v = buf_q[7:0];
            2'd1: byte_v = buf_q[15:8];
            2'd2: byte_v = buf_q[23:16];
            default: byte_v = buf_q[31:24];
        endcase
        half_v = addr_q[1] ? buf_q[31:16] : buf_q[15:0];

        unique case (size_q)
            2'b00:   ext_v = uns_q ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            2'b01:   ext_v = uns_q ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            default: ext_v = buf_q;
        endcase

        // Replace only the addressed lane of the word read back in StRead.
        merged = buf_q;
        if (size_q == 2'b00) begin
            unique case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_comb begin
        mem_A   = {addr_q[ADDR_W-1:2], 2'b00};
        mem_WE  = (state_q == StWrite);
        mem_WD  = '0;
        if (state_q == StWrite) begin
            mem_WD = (size_q == 2'b10) ? wdata_q : merged;
        end
        m0_gnt  = gnt_q[0];
        m1_gnt  = gnt_q[1];
        m0_done = (state_q == StResp) && !win_q;
        m1_done = (state_q == StResp) && win_q;
        err     = (state_q == StResp) && err_q;
        rdata   = ((state_q == StResp) && !we_q && !err_q) ? ext_v : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, arbitration/reset sequences and
// random accesses checked against a byte-array memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 0, m0_we = 0, m0_uns = 0;
    logic [1:0]  m0_size = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0;
    logic        m1_req = 0, m1_we = 0, m1_uns = 0;
    logic [1:0]  m1_size = 0;
    logic [31:0] m1_addr = 0, m1_wdata = 0;
    logic        m0_gnt, m1_gnt, m0_done, m1_done, err, mem_WE;
    logic [31:0] rdata, mem_A, mem_WD, mem_RD;

    logic [31:0] mem [0:63];
    logic        poke_en = 0;
    logic [5:0]  poke_idx = 0;
    logic [31:0] poke_data = 0;
    logic [7:0]  ref_mem [0:255];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_uns(m0_uns),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_uns(m1_uns),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_done(m0_done), .m1_done(m1_done),
        .rdata(rdata), .err(err),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
    );

    assign mem_RD = mem[mem_A[7:2]];

    always @(posedge clk) begin
        if (mem_WE) mem[mem_A[7:2]] <= mem_WD;
        else if (poke_en) mem[poke_idx] <= poke_data;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic poke(input logic [31:0] addr, input logic [31:0] w);
        poke_idx = addr[7:2];
        poke_data = w;
        poke_en = 1'b1;
        for (int i = 0; i < 4; i++) ref_mem[{addr[7:2], 2'b00} + i] = w[8*i +: 8];
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[{addr[7:2], 2'b00} + i];
        return w;
    endfunction

    // Access rules: n = 1 << size bytes, must be n-aligned, size 3 illegal.
    task automatic model_txn(input bit we, input logic [1:0] size, input bit uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rd, output bit e, output int lat);
        int n;
        logic [31:0] mask;
        n = 1 << size;
        rd = 0;
        e = (size == 2'd3) || ((addr % n) != 0);
        if (e) begin
            lat = 2;
        end else if (we) begin
            for (int i = 0; i < n; i++) ref_mem[addr[7:0] + i] = wdata[8*i +: 8];
            lat = (n == 4) ? 3 : 4;
        end else begin
            for (int i = 0; i < n; i++) rd = rd | (32'(ref_mem[addr[7:0] + i]) << (8*i));
            if (!uns && n < 4 && rd[8*n-1]) begin
                mask = (32'h1 << (8*n)) - 1;
                rd = rd | ~mask;
            end
            lat = 3;
        end
    endtask

    task automatic drive(input bit m, input bit req, input bit we, input logic [1:0] size,
                         input bit uns, input logic [31:0] addr, input logic [31:0] wdata);
        if (m) begin
            m1_req = req; m1_we = we; m1_size = size; m1_uns = uns;
            m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = req; m0_we = we; m0_size = size; m0_uns = uns;
            m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    task automatic do_txn(input bit m, input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output bit e, output int gnt_cyc,
                          output int done_cyc, output int we_cnt, output bit bad);
        bit g, d;
        rd = 0; e = 0; gnt_cyc = -1; done_cyc = -1; we_cnt = 0; bad = 0;
        @(posedge clk);
        #1 drive(m, 1'b1, we, size, uns, addr, wdata);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            g = m ? m1_gnt : m0_gnt;
            d = m ? m1_done : m0_done;
            if ((m ? m0_gnt : m1_gnt) || (m ? m0_done : m1_done)) bad = 1;
            if (g) begin
                if (gnt_cyc < 0) gnt_cyc = cyc;
                else bad = 1;
            end
            if (mem_WE) begin
                we_cnt++;
                if (mem_A != {addr[31:2], 2'b00}) bad = 1;
            end
            if (d) begin
                done_cyc = cyc;
                rd = rdata;
                e = err;
                break;
            end
            @(posedge clk);
            #1 if (gnt_cyc > 0) drive(m, 1'b0, we, size, uns, addr, wdata);
        end
        drive(m, 1'b0, we, size, uns, addr, wdata);
    endtask

    task automatic run_check(input string nm, input bit m, input bit we, input logic [1:0] size,
                             input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rd, input bit exp_err, input int exp_lat);
        logic [31:0] rd;
        bit e, bad;
        int gc, dc, wc;
        do_txn(m, we, size, uns, addr, wdata, rd, e, gc, dc, wc, bad);
        chk({nm, ".gnt_cycle"}, gc, 2);
        chk({nm, ".done_cycle"}, dc, exp_lat);
        chk({nm, ".rdata"}, rd, exp_rd);
        chk({nm, ".err"}, e, exp_err);
        chk({nm, ".we_cycles"}, wc, (we && !exp_err) ? 1 : 0);
        chk({nm, ".protocol"}, bad, 0);
        chk({nm, ".mem_word"}, mem[addr[7:2]], ref_word(addr));
    endtask

    typedef struct {
        bit          m;
        bit          we;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tbl[18];

    initial begin
        logic [31:0] mrd, e0, e1;
        bit me;
        int mlat, both_cnt, done_cnt;
        bit outst, last_m, seen_g, seen_we;
        int gm[$];
        int gcyc[$];

        tbl[0]  = '{0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 3};
        tbl[1]  = '{0, 0, 2'd2, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 3};
        tbl[2]  = '{1, 1, 2'd0, 0, 32'h22, 32'h000000AA, 32'h0,        0, 4};
        tbl[3]  = '{1, 0, 2'd2, 0, 32'h20, 32'h0,        32'h11AA3344, 0, 3};
        tbl[4]  = '{0, 1, 2'd2, 0, 32'h20, 32'h80FF7F01, 32'h0,        0, 3};
        tbl[5]  = '{1, 0, 2'd0, 0, 32'h23, 32'h0,        32'hFFFFFF80, 0, 3};
        tbl[6]  = '{0, 0, 2'd0, 1, 32'h23, 32'h0,        32'h00000080, 0, 3};
        tbl[7]  = '{1, 0, 2'd1, 0, 32'h20, 32'h0,        32'h00007F01, 0, 3};
        tbl[8]  = '{0, 0, 2'd1, 0, 32'h22, 32'h0,        32'hFFFF80FF, 0, 3};
        tbl[9]  = '{0, 1, 2'd1, 0, 32'h31, 32'h00001234, 32'h0,        1, 2};
        tbl[10] = '{1, 0, 2'd2, 0, 32'h30, 32'h0,        32'h55667788, 0, 3};
        tbl[11] = '{1, 1, 2'd1, 0, 32'h22, 32'hFFFF1234, 32'h0,        0, 4};
        tbl[12] = '{0, 0, 2'd2, 0, 32'h20, 32'h0,        32'h12347F01, 0, 3};
        tbl[13] = '{0, 0, 2'd3, 0, 32'h30, 32'h0,        32'h0,        1, 2};
        tbl[14] = '{1, 0, 2'd2, 0, 32'h12, 32'h0,        32'h0,        1, 2};
        tbl[15] = '{0, 0, 2'd0, 0, 32'h21, 32'h0,        32'h0000007F, 0, 3};
        tbl[16] = '{1, 0, 2'd1, 1, 32'h22, 32'h0,        32'h00001234, 0, 3};
        tbl[17] = '{1, 1, 2'd3, 0, 32'h30, 32'h12345678, 32'h0,        1, 2};

        // Reset values, while memory is filled with random words.
        #2;
        chk("rst.m0_gnt", m0_gnt, 0);
        chk("rst.m1_gnt", m1_gnt, 0);
        chk("rst.done", {m0_done, m1_done}, 0);
        chk("rst.err", err, 0);
        chk("rst.mem_WE", mem_WE, 0);
        chk("rst.mem_A", mem_A, 0);
        chk("rst.mem_WD", mem_WD, 0);
        chk("rst.rdata", rdata, 0);
        for (int i = 0; i < 64; i++) poke(i * 4, $urandom);
        poke(32'h20, 32'h11223344);
        poke(32'h30, 32'h55667788);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            model_txn(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
                      mrd, me, mlat);
            run_check($sformatf("tbl%0d", i), tbl[i].m, tbl[i].we, tbl[i].size, tbl[i].uns,
                      tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_err, tbl[i].exp_lat);
        end

        // Both requesters held: grants must alternate with one IDLE cycle between.
        e0 = ref_word(32'h10);
        e1 = ref_word(32'h20);
        both_cnt = 0;
        outst = 0;
        last_m = 0;
        @(posedge clk);
        #1;
        drive(0, 1, 0, 2'd2, 0, 32'h10, 0);
        drive(1, 1, 0, 2'd2, 0, 32'h20, 0);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (m0_gnt && m1_gnt) both_cnt++;
            if (m0_gnt || m1_gnt) begin
                chk("alt.done_before_next_gnt", outst, 0);
                if (gm.size() > 0) begin
                    chk("alt.alternate", m1_gnt, gm[gm.size()-1] == 0);
                    chk("alt.gnt_gap", c - gcyc[gcyc.size()-1], 3);
                end
                gm.push_back(int'(m1_gnt));
                gcyc.push_back(c);
                outst = 1;
                last_m = m1_gnt;
            end
            if (m0_done || m1_done) begin
                chk("alt.done_owner", m1_done, last_m);
                chk("alt.rdata", rdata, last_m ? e1 : e0);
                outst = 0;
            end
            if (gm.size() >= 6 && !outst) break;
            @(posedge clk);
            #1 if (gm.size() >= 6) begin
                m0_req = 0;
                m1_req = 0;
            end
        end
        m0_req = 0;
        m1_req = 0;
        chk("alt.grant_count", gm.size(), 6);
        chk("alt.double_gnt", both_cnt, 0);

        // Reset during WRITE of a sub-word store must cancel the write and the done.
        poke(32'h24, 32'hCAFEF00D);
        seen_g = 0;
        seen_we = 0;
        @(posedge clk);
        #1 drive(1, 1, 1, 2'd0, 0, 32'h24, 32'h55);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (m1_gnt) seen_g = 1;
            if (mem_WE) begin
                seen_we = 1;
                break;
            end
            @(posedge clk);
            #1 if (seen_g) m1_req = 0;
        end
        chk("rst_mid.reached_write", seen_we, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.mem_WE_async", mem_WE, 0);
        m1_req = 0;
        done_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            if (m0_done || m1_done) done_cnt++;
        end
        chk("rst_mid.no_done", done_cnt, 0);
        chk("rst_mid.mem_unchanged", mem[32'h24 >> 2], ref_word(32'h24));
        @(posedge clk);
        #1;
        drive(0, 1, 0, 2'd2, 0, 32'h24, 0);
        drive(1, 1, 0, 2'd2, 0, 32'h10, 0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid.m0_wins_gnt", m0_gnt, 1);
        chk("rst_mid.m1_waits", m1_gnt, 0);
        @(posedge clk);
        #1;
        m0_req = 0;
        m1_req = 0;
        done_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (m0_done) begin
                done_cnt++;
                chk("rst_mid.m0_rdata", rdata, ref_word(32'h24));
                break;
            end
        end
        chk("rst_mid.m0_done_seen", done_cnt, 1);

        // Random accesses against the byte-array model, biased toward aligned addresses.
        for (int i = 0; i < 80; i++) begin
            bit m, we, uns;
            logic [1:0] size;
            logic [31:0] addr, wdata;
            m = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            addr = {24'h0, 8'($urandom)};
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'd1) addr[0] = 1'b0;
                if (size == 2'd2) addr[1:0] = 2'b00;
            end
            wdata = $urandom;
            model_txn(we, size, uns, addr, wdata, mrd, me, mlat);
            run_check($sformatf("rnd%0d", i), m, we, size, uns, addr, wdata, mrd, me, mlat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
